// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin SRAM port arbiter with lockable ownership
//
// Ports:
//   clk, n_rst            clock; synchronous active-high reset
//   req/req_we/req_lock   per-requester request, write select, keep-ownership flag
//   req_addr/req_wdata    packed per-requester address / write word (index i at i*W +: W)
//   grant                 one-hot owner of the access in progress
//   ack                   one-cycle completion pulse to the owner
//   rdata                 last read word, valid from the ack cycle
//   busy                  high while an access or its ack is in flight
//   read_enable/write_enable/address/write_data   SRAM wrapper command side
//   read_data             SRAM wrapper read word
module sram_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_SIZE_BITS = 16,
  parameter int DATA_BITS      = 1536,
  parameter int ACCESS_CYCLES  = 2
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0]                  req_we,
  input  logic [NUM_REQ-1:0]                  req_lock,
  input  logic [NUM_REQ*ADDR_SIZE_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]        req_wdata,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [NUM_REQ-1:0]                  ack,
  output logic [DATA_BITS-1:0]                rdata,
  output logic                                busy,
  output logic                                read_enable,
  output logic                                write_enable,
  output logic [ADDR_SIZE_BITS-1:0]           address,
  output logic [DATA_BITS-1:0]                write_data,
  input  logic [DATA_BITS-1:0]                read_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   last_winner;
  logic [IDX_W-1:0]   lock_owner;
  logic               lock_valid;
  logic [IDX_W-1:0]   win_q;
  logic               we_q;
  logic [3:0]         cnt;
  logic               last_cycle;

  logic               win_found;
  logic [IDX_W-1:0]   win_sel;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;

  logic [NUM_REQ-1:0] grant_d;
  logic [NUM_REQ-1:0] ack_d;
  logic               busy_d;
  logic               re_d;
  logic               we_d;
  logic               sel_we;

  assign last_cycle = (cnt == 4'(ACCESS_CYCLES - 1));

  // Winner select. The scan runs from the farthest candidate down to the
  // nearest so the last hit is the first requester after last_winner.
  always_comb begin
    win_found = 1'b0;
    win_sel   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (lock_valid) begin
      win_found = req[lock_owner];
      win_sel   = lock_owner;
    end else begin
      for (int i = NUM_REQ; i >= 1; i--) begin
        cand     = (int'(last_winner) + i) % NUM_REQ;
        cand_idx = IDX_W'(cand);
        if (req[cand_idx]) begin
          win_found = 1'b1;
          win_sel   = cand_idx;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_found) next_state = ACCESS;
      ACCESS:  if (last_cycle) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, so every port
  // changes in step with the state it belongs to.
  always_comb begin
    grant_d = grant;
    ack_d   = '0;
    sel_we  = we_q;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_sel] = 1'b1;
          sel_we           = req_we[win_sel];
        end
      end
      ACCESS:  if (last_cycle) ack_d[win_q] = 1'b1;
      ACK:     grant_d = '0;
      default: grant_d = '0;
    endcase
    busy_d = (next_state != IDLE);
    re_d   = (next_state == ACCESS) && !sel_we;
    we_d   = (next_state == ACCESS) && sel_we;
  end

  // Output registers and access datapath
  always_ff @(posedge clk) begin
    if (n_rst) begin
      grant        <= '0;
      ack          <= '0;
      busy         <= 1'b0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      address      <= '0;
      write_data   <= '0;
      rdata        <= '0;
      cnt          <= '0;
      we_q         <= 1'b0;
      win_q        <= '0;
      lock_valid   <= 1'b0;
      lock_owner   <= '0;
      last_winner  <= IDX_W'(NUM_REQ - 1);
    end else begin
      grant        <= grant_d;
      ack          <= ack_d;
      busy         <= busy_d;
      read_enable  <= re_d;
      write_enable <= we_d;
      case (state)
        IDLE: begin
          if (win_found) begin
            win_q      <= win_sel;
            we_q       <= req_we[win_sel];
            address    <= req_addr[int'(win_sel)*ADDR_SIZE_BITS +: ADDR_SIZE_BITS];
            write_data <= req_wdata[int'(win_sel)*DATA_BITS +: DATA_BITS];
            cnt        <= '0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          // SRAM word is sampled on the final enable cycle; writes keep rdata
          if (last_cycle && !we_q) rdata <= read_data;
        end
        ACK: begin
          last_winner <= win_q;
          lock_valid  <= req_lock[win_q];
          lock_owner  <= win_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter
module tb_sram_arbiter;

  localparam int NR = 3;
  localparam int AW = 16;
  localparam int DW = 1536;
  localparam int AC = 2;

  logic               clk = 1'b0;
  logic               n_rst;
  logic [NR-1:0]      req;
  logic [NR-1:0]      req_we;
  logic [NR-1:0]      req_lock;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   req_wdata;
  logic [NR-1:0]      grant;
  logic [NR-1:0]      ack;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic               read_enable;
  logic               write_enable;
  logic [AW-1:0]      address;
  logic [DW-1:0]      write_data;
  logic [DW-1:0]      read_data;

  sram_arbiter #(
    .NUM_REQ(NR), .ADDR_SIZE_BITS(AW), .DATA_BITS(DW), .ACCESS_CYCLES(AC)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .ack(ack), .rdata(rdata), .busy(busy),
    .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .write_data(write_data), .read_data(read_data)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = {a ^ 16'(k), 16'hC3A5};
    return w;
  endfunction

  function automatic logic [DW-1:0] wpat(input logic [7:0] s);
    logic [DW-1:0] w;
    for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = {s, 8'(k), 16'h5EED};
    return w;
  endfunction

  // SRAM model: each line holds a fixed address-derived pattern
  assign read_data = pat(address);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual_lo=%0h required_lo=%0h", name, act[63:0], exp[63:0]);
    end
  endtask

  typedef struct { int idx; logic [DW-1:0] rd; } ack_exp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wd; } acc_exp_t;

  ack_exp_t ack_q[$];
  acc_exp_t acc_q[$];

  task automatic exp_ack(input int idx, input logic [DW-1:0] rd);
    ack_exp_t e;
    e.idx = idx;
    e.rd  = rd;
    ack_q.push_back(e);
  endtask

  task automatic exp_acc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    acc_exp_t e;
    e.we   = we;
    e.addr = a;
    e.wd   = wd;
    acc_q.push_back(e);
  endtask

  // Ack monitor: completion order, owner, read data, grant-to-ack latency, bubble
  initial begin
    int grant_rise;
    int last_ack;
    logic [NR-1:0] prev_grant;
    ack_exp_t e;
    grant_rise = 0;
    last_ack   = -1;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (grant != '0 && prev_grant == '0) begin
        grant_rise = cyc;
        if (last_ack >= 0) chk("ack_to_next_grant_ge2", 64'(cyc - last_ack >= 2), 64'd1);
      end
      prev_grant = grant;
      if (ack != '0) begin
        if (ack_q.size() == 0) begin
          chk("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          e = ack_q.pop_front();
          chk("ack_onehot", 64'(ack), 64'd1 << e.idx);
          chk("grant_at_ack", 64'(grant), 64'd1 << e.idx);
          chk_data("rdata_at_ack", rdata, e.rd);
          chk("grant_to_ack_cycles", 64'(cyc - grant_rise), 64'(AC));
        end
        last_ack = cyc;
      end
    end
  end

  // SRAM-side monitor: enable run length, stability, address and write word
  initial begin
    int run;
    logic cur_we;
    logic stable;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wd;
    acc_exp_t a;
    run = 0;
    cur_we = 1'b0;
    stable = 1'b1;
    cur_addr = '0;
    cur_wd = '0;
    forever begin
      @(negedge clk);
      if (read_enable || write_enable) begin
        if (run == 0) begin
          cur_we   = write_enable;
          cur_addr = address;
          cur_wd   = write_data;
          stable   = 1'b1;
        end else if (write_enable !== cur_we || address !== cur_addr || write_data !== cur_wd) begin
          stable = 1'b0;
        end
        if (read_enable && write_enable) stable = 1'b0;
        run++;
      end else if (run > 0) begin
        chk("enable_cycles", 64'(run), 64'(AC));
        chk("access_held_stable", 64'(stable), 64'd1);
        if (acc_q.size() == 0) begin
          chk("unexpected_access", 64'(run), 64'd0);
        end else begin
          a = acc_q.pop_front();
          chk("access_we", 64'(cur_we), 64'(a.we));
          chk("access_addr", 64'(cur_addr), 64'(a.addr));
          if (a.we) chk_data("access_wdata", cur_wd, a.wd);
        end
        run = 0;
      end
    end
  end

  // One access by requester idx; returns on the cycle after its ack.
  task automatic access(input int idx, input logic we, input logic lock, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input bit last, output int ack_cyc);
    int n;
    req_we[idx]             = we;
    req_lock[idx]           = lock;
    req_addr[idx*AW +: AW]  = a;
    req_wdata[idx*DW +: DW] = wd;
    req[idx]                = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack[idx] !== 1'b1 && n < 200);
    if (ack[idx] !== 1'b1) chk("ack_wait", 64'(ack[idx]), 64'd1);
    ack_cyc = cyc;
    if (last) req[idx] = 1'b0;
    @(negedge clk);
  endtask

  task automatic rr_pair(input int idx);
    int t;
    access(idx, 1'b0, 1'b0, 16'h0020 + 16'(idx), '0, 1'b0, t);
    access(idx, 1'b0, 1'b0, 16'h0030 + 16'(idx), '0, 1'b1, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t0;
    int n;
    req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 16'h0020 + 16'(i);

    // Reset with all requesters asserted
    n_rst = 1'b1;
    req   = 3'b111;
    repeat (2) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_read_enable", 64'(read_enable), 64'd0);
    chk("rst_write_enable", 64'(write_enable), 64'd0);
    chk("rst_address", 64'(address), 64'd0);
    chk_data("rst_write_data", write_data, '0);
    chk_data("rst_rdata", rdata, '0);

    // Round robin from reset: 0,1,2,0,1,2
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) begin
        exp_ack(i, pat(16'(16'h0020 + 16'(r*16 + i))));
        exp_acc(1'b0, 16'(16'h0020 + 16'(r*16 + i)), '0);
      end
    n_rst = 1'b0;
    fork
      rr_pair(0);
      rr_pair(1);
      rr_pair(2);
    join
    repeat (3) @(negedge clk);

    // Lock: requester 0 read+write 0x0010 while requester 2 waits
    exp_ack(0, pat(16'h0010));
    exp_ack(0, pat(16'h0010));
    exp_ack(2, pat(16'h0050));
    exp_acc(1'b0, 16'h0010, '0);
    exp_acc(1'b1, 16'h0010, wpat(8'h01));
    exp_acc(1'b0, 16'h0050, '0);
    fork
      begin
        access(0, 1'b0, 1'b1, 16'h0010, '0, 1'b0, t);
        access(0, 1'b1, 1'b0, 16'h0010, wpat(8'h01), 1'b1, t);
      end
      access(2, 1'b0, 1'b0, 16'h0050, '0, 1'b1, t);
    join
    repeat (3) @(negedge clk);

    // Single read with request-to-ack latency
    exp_ack(1, pat(16'h0040));
    exp_acc(1'b0, 16'h0040, '0);
    t0 = cyc;
    access(1, 1'b0, 1'b0, 16'h0040, '0, 1'b1, t);
    chk("single_read_latency", 64'(t - t0), 64'(AC + 1));
    repeat (3) @(negedge clk);

    // Write leaves rdata holding the earlier read
    exp_ack(0, pat(16'h0001));
    exp_ack(0, pat(16'h0001));
    exp_acc(1'b0, 16'h0001, '0);
    exp_acc(1'b1, 16'h0001, wpat(8'h02));
    access(0, 1'b0, 1'b0, 16'h0001, '0, 1'b0, t);
    access(0, 1'b1, 1'b0, 16'h0001, wpat(8'h02), 1'b1, t);
    repeat (3) @(negedge clk);

    // Reset during the second cycle of a locked access
    exp_ack(0, pat(16'h0003));
    exp_ack(1, pat(16'h0004));
    exp_acc(1'b0, 16'h0003, '0);
    exp_acc(1'b0, 16'h0002, '0);
    exp_acc(1'b0, 16'h0004, '0);
    access(0, 1'b0, 1'b1, 16'h0003, '0, 1'b0, t);
    req_we[0] = 1'b0;
    req_lock[0] = 1'b1;
    req_addr[0 +: AW] = 16'h0002;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant[0] !== 1'b1 && n < 50);
    chk("abort_grant_seen", 64'(grant), 64'd1);
    @(negedge clk);
    n_rst = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    chk("abort_read_enable", 64'(read_enable), 64'd0);
    chk("abort_write_enable", 64'(write_enable), 64'd0);
    chk("abort_ack", 64'(ack), 64'd0);
    chk("abort_grant", 64'(grant), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk_data("abort_rdata", rdata, '0);
    n_rst = 1'b0;
    access(1, 1'b0, 1'b0, 16'h0004, '0, 1'b1, t);
    repeat (4) @(negedge clk);

    chk("ack_queue_left", 64'(ack_q.size()), 64'd0);
    chk("access_queue_left", 64'(acc_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
